// File: rtl/stack_seq_ctrl.sv
// stack_seq_ctrl: multi-cycle PUSH/POP/CALL/RET sequencer that owns SP and steers the shared ALU to SP+/-4.
// Define STACK_BOUNDS_CHECK_EN to reject overflowing pushes and underflowing pops at accept.
module stack_seq_ctrl #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] SP_RESET = 32'h0000_FFFC,
    parameter logic [XLEN-1:0] STACK_LIMIT = 32'h0000_F000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] push_data,
    input  logic [XLEN-1:0] exe_out,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] sp_out,
    output logic            alu_a_sel,
    output logic [1:0]      alu_b_sel,
    output logic            alu_sub,
    output logic            mem_in_sel,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [XLEN-1:0] pop_data,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_target,
    output logic            busy,
    output logic            done,
    output logic            err
);
    typedef enum logic [2:0] {IDLE, DEC, WR, RD, INC, JMP, DONE, ERR} state_t;
    state_t state, state_nx;
    logic [1:0] op_q;
    logic [XLEN-1:0] data_q, tgt_q;
    logic viol;
    // op[0] marks the reading ops (POP/RET), op[1] the ones that jump (CALL/RET)
`ifdef STACK_BOUNDS_CHECK_EN
    assign viol = op[0] ? (sp_out >= SP_RESET) : (sp_out - XLEN'(4) < STACK_LIMIT);
`else
    logic unused_limit;
    assign unused_limit = ^STACK_LIMIT;
    assign viol = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            sp_out <= SP_RESET;
            pop_data <= '0;
            op_q <= '0;
            data_q <= '0;
            tgt_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                op_q <= op;
                data_q <= push_data;
                tgt_q <= push_data;
            end
            if (state == DEC || state == INC) sp_out <= exe_out;
            if (state == RD && mem_ack) pop_data <= mem_rdata;
        end
    always_comb begin
        state_nx = state;
        alu_a_sel = 1'b0;
        alu_b_sel = 2'b00;
        alu_sub = 1'b0;
        mem_in_sel = 1'b0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        pc_load = 1'b0;
        pc_target = '0;
        busy = 1'b1;
        done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = viol ? ERR : op[0] ? RD : DEC;
            end
            DEC: begin
                alu_a_sel = 1'b1;
                alu_b_sel = 2'b10;
                alu_sub = 1'b1;
                state_nx = WR;
            end
            WR: begin
                mem_req = 1'b1;
                mem_we = 1'b1;
                mem_in_sel = 1'b1;
                mem_addr = sp_out;
                mem_wdata = data_q;
                if (mem_ack) state_nx = op_q[1] ? JMP : DONE;
            end
            RD: begin
                mem_req = 1'b1;
                mem_in_sel = 1'b1;
                mem_addr = sp_out;
                if (mem_ack) state_nx = INC;
            end
            INC: begin
                alu_a_sel = 1'b1;
                alu_b_sel = 2'b10;
                state_nx = op_q[1] ? JMP : DONE;
            end
            JMP: begin
                pc_load = 1'b1;
                pc_target = op_q[0] ? pop_data : tgt_q;
                state_nx = DONE;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                busy = 1'b0;
                done = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end
`ifdef STACK_BOUNDS_CHECK_EN
    assign err = (state == ERR);
`else
    assign err = 1'b0;
`endif
endmodule
